// File: rtl/connect_arbiter_pkg.sv
// Shared definitions for the round-robin packet join: default packet width
// and the buffer occupancy type.
package connect_arbiter_pkg;

  localparam int PACKET_WIDTH = 32;

  typedef logic [1:0] count_t;
  localparam count_t BUF_EMPTY = 2'd0;
  localparam count_t BUF_FULL  = 2'd2;

endpackage

// File: rtl/connect_arbiter_rr_pick.sv
// Rotated priority search: starting just below the last grant and wrapping,
// the first requesting port wins, so the previous winner is tried last.
module connect_arbiter_rr_pick #(
  parameter int N = 3,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [W-1:0] winner,
  output logic         any_req
);

  int idx;

  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last) + N - k) % N;
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        winner  = W'(idx);
      end
    end
  end

endmodule

// File: rtl/connect_arbiter.sv
// Fair N-to-1 packet join feeding a 2-entry output buffer; each delivered
// packet carries the index of the port it came from.
module connect_arbiter
  import connect_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH  = PACKET_WIDTH,
  parameter int CONNECT_NUM = 3,
  parameter int SRC_WIDTH   = $clog2(CONNECT_NUM)
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic [CONNECT_NUM-1:0]            RECEIVE_VALID,
  output logic [CONNECT_NUM-1:0]            RECEIVE_READY,
  input  logic [DATA_WIDTH*CONNECT_NUM-1:0] RECEIVE_DATA,
  output logic                              SEND_VALID,
  input  logic                              SEND_READY,
  output logic [DATA_WIDTH-1:0]             SEND_DATA,
  output logic [SRC_WIDTH-1:0]              SEND_SOURCE
);

  logic [SRC_WIDTH-1:0]  last;
  logic [SRC_WIDTH-1:0]  winner;
  logic                  any_req;
  count_t                count;
  logic                  rd_ptr;
  logic                  wr_ptr;
  logic [DATA_WIDTH-1:0] buf_data [2];
  logic [SRC_WIDTH-1:0]  buf_src  [2];
  logic [DATA_WIDTH-1:0] in_data;
  logic                  push;
  logic                  pop;

  connect_arbiter_rr_pick #(
    .N(CONNECT_NUM),
    .W(SRC_WIDTH)
  ) u_pick (
    .req    (RECEIVE_VALID),
    .last   (last),
    .winner (winner),
    .any_req(any_req)
  );

  // Ready sees only request inputs and registered state, never SEND_READY.
  assign push = RST && any_req && (count != BUF_FULL);
  assign pop  = (count != BUF_EMPTY) && SEND_READY;

  always_comb begin
    RECEIVE_READY = '0;
    in_data       = '0;
    for (int i = 0; i < CONNECT_NUM; i++) begin
      if (winner == SRC_WIDTH'(i)) begin
        RECEIVE_READY[i] = push;
        in_data          = RECEIVE_DATA[DATA_WIDTH*i +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      last        <= '0;
      count       <= BUF_EMPTY;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      buf_data[0] <= '0;
      buf_data[1] <= '0;
      buf_src[0]  <= '0;
      buf_src[1]  <= '0;
    end else begin
      if (push) begin
        buf_data[wr_ptr] <= in_data;
        buf_src[wr_ptr]  <= winner;
        wr_ptr           <= ~wr_ptr;
        last             <= winner;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      if (push && !pop) begin
        count <= count + 2'd1;
      end else if (pop && !push) begin
        count <= count - 2'd1;
      end
    end
  end

  assign SEND_VALID  = (count != BUF_EMPTY);
  assign SEND_DATA   = buf_data[rd_ptr];
  assign SEND_SOURCE = buf_src[rd_ptr];

endmodule

// File: tb/tb_connect_arbiter.sv
// Randomized scoreboard bench for connect_arbiter: a behavioural model predicts
// grants and queues expected packets; a negedge monitor checks outputs.
module tb_connect_arbiter;

  localparam int DW = 32;
  localparam int N  = 3;
  localparam int SW = 2;

  logic            CLK = 1'b0;
  logic            RST = 1'b0;
  logic [N-1:0]    RECEIVE_VALID = '0;
  logic [N-1:0]    RECEIVE_READY;
  logic [DW*N-1:0] RECEIVE_DATA = '0;
  logic            SEND_VALID;
  logic            SEND_READY = 1'b0;
  logic [DW-1:0]   SEND_DATA;
  logic [SW-1:0]   SEND_SOURCE;

  connect_arbiter #(.DATA_WIDTH(DW), .CONNECT_NUM(N), .SRC_WIDTH(SW)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .RECEIVE_VALID(RECEIVE_VALID),
    .RECEIVE_READY(RECEIVE_READY),
    .RECEIVE_DATA (RECEIVE_DATA),
    .SEND_VALID   (SEND_VALID),
    .SEND_READY   (SEND_READY),
    .SEND_DATA    (SEND_DATA),
    .SEND_SOURCE  (SEND_SOURCE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [DW-1:0] data;
    int            src;
  } pkt_t;

  pkt_t exp_q[$];
  int   mdl_last = 0;
  int   mdl_cnt  = 0;
  int   vectors  = 0;
  int   miscompares = 0;

  // The winner is the valid port closest below the last grant, cyclically.
  function automatic int pick(input logic [N-1:0] v, input int last);
    int best;
    int bestd;
    int d;
    best  = -1;
    bestd = N;
    for (int p = 0; p < N; p++) begin
      if (v[p]) begin
        d = (last - p - 1 + 2 * N) % N;
        if (d < bestd) begin
          bestd = d;
          best  = p;
        end
      end
    end
    return best;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int g;
    g = pick(RECEIVE_VALID, mdl_last);
    if (RST && mdl_cnt < 2 && g >= 0) return N'(1 << g);
    return '0;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model advances on every rising edge out of reset.
  always @(posedge CLK) begin
    if (RST) begin
      int g;
      bit acc;
      bit pp;
      pkt_t p;
      g   = pick(RECEIVE_VALID, mdl_last);
      acc = (g >= 0) && (mdl_cnt < 2);
      pp  = (mdl_cnt != 0) && SEND_READY;
      if (acc) begin
        p.data   = RECEIVE_DATA[DW*g +: DW];
        p.src    = g;
        exp_q.push_back(p);
        mdl_last = g;
      end
      mdl_cnt = mdl_cnt + int'(acc) - int'(pp);
    end
  end

  // Monitor: the head shown now is the one a transfer at the next edge takes.
  always @(negedge CLK) begin
    if (RST) begin
      pkt_t e;
      check("send_valid", 64'(SEND_VALID), 64'(mdl_cnt != 0));
      check("receive_ready", 64'(RECEIVE_READY), 64'(exp_ready()));
      if (SEND_VALID && SEND_READY) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pkt", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("send_data", 64'(SEND_DATA), 64'(e.data));
          check("send_source", 64'(SEND_SOURCE), 64'(e.src));
        end
      end
    end
  end

  task automatic randomize_data();
    for (int i = 0; i < N; i++) RECEIVE_DATA[DW*i +: DW] = $urandom;
  endtask

  task automatic drive_cycles(input int cycles, input int valid_pct, input int ready_pct);
    for (int c = 0; c < cycles; c++) begin
      @(posedge CLK);
      #1;
      for (int i = 0; i < N; i++) RECEIVE_VALID[i] = ($urandom_range(99) < valid_pct);
      SEND_READY = ($urandom_range(99) < ready_pct);
      randomize_data();
    end
  endtask

  task automatic reset_model();
    exp_q.delete();
    mdl_cnt  = 0;
    mdl_last = 0;
  endtask

  initial begin
    RST = 1'b0;
    RECEIVE_VALID = '1;
    randomize_data();
    #12;
    check("reset_ready", 64'(RECEIVE_READY), 64'(0));
    check("reset_send_valid", 64'(SEND_VALID), 64'(0));
    check("reset_send_data", 64'(SEND_DATA), 64'(0));
    check("reset_send_source", 64'(SEND_SOURCE), 64'(0));
    @(posedge CLK);
    #1;
    RST = 1'b1;
    SEND_READY = 1'b1;
    #1;
    check("first_grant_port2", 64'(RECEIVE_READY), 64'(3'b100));

    // All ports valid, sink stalled: buffer fills with ports 2 then 1.
    SEND_READY = 1'b0;
    repeat (4) begin
      @(posedge CLK);
      #1;
      randomize_data();
    end
    check("full_ready_low", 64'(RECEIVE_READY), 64'(0));
    check("full_head_src2", 64'(SEND_SOURCE), 64'(2));

    drive_cycles(6, 100, 100);
    drive_cycles(300, 60, 70);
    drive_cycles(200, 90, 30);
    drive_cycles(200, 30, 95);

    // Asynchronous reset in mid-cycle with the buffer likely full.
    drive_cycles(6, 100, 0);
    #3;
    RST = 1'b0;
    #1;
    reset_model();
    check("async_rst_send_valid", 64'(SEND_VALID), 64'(0));
    check("async_rst_ready", 64'(RECEIVE_READY), 64'(0));
    @(posedge CLK);
    #1;
    RECEIVE_VALID = 3'b011;
    RST = 1'b1;
    #1;
    check("post_rst_grant_port1", 64'(RECEIVE_READY), 64'(3'b010));

    drive_cycles(400, 70, 60);

    // Drain everything and confirm nothing was lost.
    @(posedge CLK);
    #1;
    RECEIVE_VALID = '0;
    SEND_READY = 1'b1;
    repeat (5) @(posedge CLK);
    #1;
    check("drained_queue", 64'(exp_q.size()), 64'(0));
    check("drained_send_valid", 64'(SEND_VALID), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/connect_arbiter.md
# connect_arbiter

Fair, buffered N-to-1 packet join for the valid/ready packet network. It accepts packets from CONNECT_NUM upstream echo-style senders and grants them in round-robin order. It delivers them through a 2-entry output buffer, giving one packet per cycle with no combinational path from SEND_READY to any RECEIVE_READY. It sits where a plain combinational join would otherwise feed a single consumer, and it additionally reports the source index of each packet.

## Interface
- DATA_WIDTH, default PACKET_WIDTH: packet width in bits.
- CONNECT_NUM, default 3: number of upstream ports, minimum 2.
- SRC_WIDTH, default $clog2(CONNECT_NUM): width of the source index.

- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-low (RST=0 resets).
- RECEIVE_VALID  in  CONNECT_NUM  per-port packet valid.
- RECEIVE_READY  out  CONNECT_NUM  per-port accept; at most one bit high.
- RECEIVE_DATA  in  DATA_WIDTH*CONNECT_NUM  port i occupies bits [DATA_WIDTH*(i+1)-1 -: DATA_WIDTH].
- SEND_VALID  out  1  head of buffer valid.
- SEND_READY  in  1  downstream accept.
- SEND_DATA  out  DATA_WIDTH  head packet.
- SEND_SOURCE  out  SRC_WIDTH  port index the head packet came from.

## Operation
- Transfer on any port occurs when VALID and READY are both high at a rising CLK edge.
- State:
  - LAST: index of the most recent grant.
  - COUNT: 0..2, buffer occupancy.
  - Two buffer entries, each holding {data, source}.
  - Read pointer and write pointer, 1 bit each.
- Grant search is descending with wrap-around: LAST-1, LAST-2, …, 0, CONNECT_NUM-1, …, LAST. The first port with RECEIVE_VALID=1 wins.
  - After reset LAST=0, so the search order is CONNECT_NUM-1 down to 0.
  - The port just granted has lowest priority next cycle.
- RECEIVE_READY[g]=1 only when g is the winner and COUNT<2. All other ready bits are 0.
  - Ready depends combinationally on RECEIVE_VALID and registered state only.
- On an accept:
  - Write {RECEIVE_DATA[g], g} at the write pointer.
  - Set LAST←g.
  - Toggle the write pointer.
- On a SEND transfer: toggle the read pointer.
- COUNT update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop (COUNT=1), or when neither happens.
  - Push with COUNT=2 is impossible, because ready is low.
- SEND_VALID = (COUNT≠0). SEND_DATA and SEND_SOURCE are the entry at the read pointer.
- Upstream valid is not required to stay high without a grant. The arbiter never assumes stickiness; it re-evaluates every cycle.
- No packet is dropped, duplicated or reordered relative to grant order.

## Timing
- Reset (RST=0), effective immediately without a clock edge:
  - COUNT=0, LAST=0, pointers 0, entries 0.
  - Outputs: SEND_VALID=0, SEND_DATA=0, SEND_SOURCE=0, RECEIVE_READY all 0 (forced while RST=0).
- Latency: a packet accepted at edge t is visible on SEND_* after edge t, i.e. in cycle t+1. Minimum 1 cycle.
- Throughput: 1 packet/cycle sustained when SEND_READY=1.
- Full (COUNT=2): all RECEIVE_READY low. Recovery on the cycle after the first pop.
- Empty (COUNT=0): SEND_VALID low. SEND_DATA holds its last value and is don't-care.
- SEND_VALID never drops once asserted until it is accepted, except on reset.
- Reset mid-operation discards buffered packets. The first grant after release follows the reset order.

## Structure
- Shared package/include (param.vh):
  - PACKET_WIDTH.
  - A clog2 helper, if not already present.
- Sub-module rr_pick (combinational):
  - Inputs: request vector and LAST.
  - Outputs: winner index and any-request flag.
  - Implemented as a rotated priority search.
- Buffer is inline: 2 registers, 2 pointers, COUNT.

## Test plan
- Reset with all RECEIVE_VALID=1 and RST=0 → RECEIVE_READY=000, SEND_VALID=0. First edge after release → port 2 accepted.
- Ports 0,1,2 each send one packet simultaneously, SEND_READY=1 → SEND_SOURCE 2,1,0 on consecutive cycles, data matching per port, first output 1 cycle after first accept.
- Only ports 0 and 1 valid, LAST=0 → outputs source 1 then 0.
- Ports 0 and 2 continuously valid for 6 packets → sources 2,0,2,0,2,0. Port 1 raised after the third grant (port 2) → port 1 is granted next.
- SEND_READY=0 with all ports valid → exactly 2 accepts (sources 2,1), then RECEIVE_READY=000 and SEND_VALID held with source 2. SEND_READY=1 → stream 2,1,0,2,… with no loss or duplicate.
- Assert RST=0 mid-cycle with COUNT=2 → SEND_VALID falls before the next edge. After release, no stale packet appears and the first grant goes to the highest valid port.
